// File: rtl/serial_subtractor_16bit.sv
// Digit-serial 16-bit unsigned subtractor: one 4-bit digit per clock, LSD first,
// producing (a - b - bin) mod 2^16 and the borrow out of bit 15.
module serial_subtractor_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic [15:0] diff,
  output logic        bout,
  output logic        busy,
  output logic        done
);

  localparam int DATA_W  = 16;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [1:0]          idx;
  logic [DATA_W-1:0]   a_w;
  logic [DATA_W-1:0]   b_w;
  logic [DATA_W-1:0]   res_w;
  logic                borrow;
  logic [3:0]          lsb;
  logic [DIGIT_W:0]    digit;

  // One digit of a - b - borrow_in; MSB of the result is the borrow out.
  function automatic logic [DIGIT_W:0] digit_sub(input logic [DIGIT_W-1:0] x,
                                                 input logic [DIGIT_W-1:0] y,
                                                 input logic               bi);
    digit_sub = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bi};
  endfunction

  assign lsb = {idx, 2'b00};

  always_comb begin
    digit = digit_sub(a_w[lsb +: DIGIT_W], b_w[lsb +: DIGIT_W], borrow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      a_w    <= '0;
      b_w    <= '0;
      res_w  <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_w    <= a;
            b_w    <= b;
            res_w  <= '0;
            borrow <= bin;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          res_w[lsb +: DIGIT_W] <= digit[DIGIT_W-1:0];
          borrow                <= digit[DIGIT_W];
          if (idx == 2'd3) begin
            // Last digit goes straight to diff; idx stays parked at 3.
            diff  <= {digit[DIGIT_W-1:0], res_w[11:0]};
            bout  <= digit[DIGIT_W];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 2'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Self-checking bench for serial_subtractor_16bit: directed corner cases plus
// random operands checked against a plain-integer subtraction model.
module tb_serial_subtractor_16bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic [15:0] diff;
  logic        bout;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  serial_subtractor_16bit dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .diff (diff),
    .bout (bout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer subtraction.
  function automatic logic [15:0] model_diff(input logic [15:0] x, input logic [15:0] y, input logic bi);
    int d;
    d = int'(x) - int'(y) - int'(bi);
    return 16'(d);
  endfunction

  function automatic logic model_bout(input logic [15:0] x, input logic [15:0] y, input logic bi);
    return (int'(x) < int'(y) + int'(bi));
  endfunction

  // Drives one operation and records what the DUT did over the following 8 cycles.
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                       output logic [15:0] od, output logic ob, output int busy_n,
                       output int done_n, output int done_k, output bit held);
    logic [15:0] prev;
    prev = diff;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    busy_n = 0; done_n = 0; done_k = -1; held = 1'b1; od = '0; ob = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
        od = diff; ob = bout;
      end else if (done_k < 0 && diff !== prev) begin
        held = 1'b0;
      end
      if (k < 7) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (diff !== 16'h0000) begin failures++; $display("FAIL reset_diff got=%h want=0000", diff); end
    checks++; if (bout !== 1'b0) begin failures++; $display("FAIL reset_bout got=%b want=0", bout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [15:0] va [5] = '{16'd5, 16'd2, 16'd0, 16'd100, 16'h1000};
    logic [15:0] vb [5] = '{16'd2, 16'd4, 16'd0, 16'd100, 16'h0001};
    logic        vc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] ed [5] = '{16'd3, 16'hFFFD, 16'hFFFF, 16'h0000, 16'h0FFF};
    logic        eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] od;
    logic        ob;
    int          busy_n, done_n, done_k;
    bit          held;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vc[i], od, ob, busy_n, done_n, done_k, held);
      checks++; if (od !== ed[i]) begin failures++; $display("FAIL dir%0d_diff got=%h want=%h", i, od, ed[i]); end
      checks++; if (ob !== eb[i]) begin failures++; $display("FAIL dir%0d_bout got=%b want=%b", i, ob, eb[i]); end
      checks++; if (busy_n != 4) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d want=4", i, busy_n); end
      checks++; if (done_n != 1) begin failures++; $display("FAIL dir%0d_done_pulses got=%0d want=1", i, done_n); end
      checks++; if (done_k != 4) begin failures++; $display("FAIL dir%0d_latency got=%0d want=4", i, done_k); end
      checks++; if (held !== 1'b1) begin failures++; $display("FAIL dir%0d_diff_held got=%b want=1", i, held); end
    end
  endtask

  task automatic test_random;
    logic [15:0] ra, rb, od;
    logic        rc, ob;
    int          busy_n, done_n, done_k;
    bit          held;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (i == 0) begin ra = 16'hFFFF; rb = 16'h0000; rc = 1'b0; end
      if (i == 1) begin ra = 16'h0000; rb = 16'hFFFF; rc = 1'b1; end
      do_op(ra, rb, rc, od, ob, busy_n, done_n, done_k, held);
      checks++; if (od !== model_diff(ra, rb, rc)) begin failures++; $display("FAIL rand%0d_diff a=%h b=%h bin=%b got=%h want=%h", i, ra, rb, rc, od, model_diff(ra, rb, rc)); end
      checks++; if (ob !== model_bout(ra, rb, rc)) begin failures++; $display("FAIL rand%0d_bout a=%h b=%h bin=%b got=%b want=%b", i, ra, rb, rc, ob, model_bout(ra, rb, rc)); end
      checks++; if (done_n != 1 || done_k != 4) begin failures++; $display("FAIL rand%0d_timing got_pulses=%0d got_k=%0d want=1/4", i, done_n, done_k); end
    end
  endtask

  task automatic test_start_in_run;
    logic [15:0] od;
    int          done_n, done_k;
    a = 16'd9; b = 16'd3; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    done_n = 0; done_k = -1; od = '0;
    for (int k = 0; k < 10; k++) begin
      start = (k < 2); a = 16'd1; b = 16'd1;
      if (done) begin done_n++; if (done_k < 0) done_k = k; od = diff; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (od !== 16'd6) begin failures++; $display("FAIL run_start_diff got=%0d want=6", od); end
    checks++; if (done_n != 1) begin failures++; $display("FAIL run_start_pulses got=%0d want=1", done_n); end
    checks++; if (done_k != 4) begin failures++; $display("FAIL run_start_latency got=%0d want=4", done_k); end
  endtask

  task automatic test_rst_in_run;
    int done_n;
    a = 16'd5; b = 16'd2; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (diff !== 16'h0000) begin failures++; $display("FAIL abort_diff got=%h want=0000", diff); end
    checks++; if (bout !== 1'b0) begin failures++; $display("FAIL abort_bout got=%b want=0", bout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", done); end
    done_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) done_n++;
    end
    checks++; if (done_n != 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", done_n); end
  endtask

  task automatic test_rst_priority;
    logic [15:0] od;
    int          done_k;
    a = 16'd50; b = 16'd8; bin = 1'b0; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_prio_busy got=%b want=0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_release_accept got=%b want=1", busy); end
    done_k = -1; od = '0;
    for (int k = 0; k < 10 && done_k < 0; k++) begin
      if (done) begin done_k = k; od = diff; end
      else begin @(posedge clk); #1; end
    end
    checks++; if (od !== 16'd42) begin failures++; $display("FAIL rst_release_diff got=%0d want=42", od); end
    checks++; if (done_k != 4) begin failures++; $display("FAIL rst_release_latency got=%0d want=4", done_k); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int          k1, k2;
    logic [15:0] d1, d2;
    logic        b2, acc_busy, acc_done;
    a = 16'd20; b = 16'd5; bin = 1'b0; start = 1'b1;
    k1 = -1; k2 = -1; d1 = '0; d2 = '0; b2 = 1'b0; acc_busy = 1'b0; acc_done = 1'b1;
    for (int k = 0; k < 30 && k2 < 0; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (k1 < 0) begin k1 = k; d1 = diff; a = 16'd7; b = 16'd8; bin = 1'b0; end
        else begin k2 = k; d2 = diff; b2 = bout; end
      end else if (k1 >= 0 && k == k1 + 1) begin
        acc_busy = busy; acc_done = done; start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
      end
    end
    start = 1'b0;
    checks++; if (k1 != 4) begin failures++; $display("FAIL b2b_first_latency got=%0d want=4", k1); end
    checks++; if (d1 !== 16'd15) begin failures++; $display("FAIL b2b_first_diff got=%0d want=15", d1); end
    checks++; if (k2 - k1 != 5) begin failures++; $display("FAIL b2b_spacing got=%0d want=5", k2 - k1); end
    checks++; if (acc_busy !== 1'b1 || acc_done !== 1'b0) begin failures++; $display("FAIL b2b_accept busy=%b done=%b want=1/0", acc_busy, acc_done); end
    checks++; if (d2 !== 16'hFFFF) begin failures++; $display("FAIL b2b_second_diff got=%h want=ffff", d2); end
    checks++; if (b2 !== 1'b1) begin failures++; $display("FAIL b2b_second_bout got=%b want=1", b2); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_return_idle done=%b busy=%b want=0/0", done, busy); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    test_reset;
    test_directed;
    test_random;
    test_start_in_run;
    test_rst_in_run;
    test_rst_priority;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
